gs_i2s_tx: RTL and testbench



---
 rtl/gs_audio_pkg.sv | 20 ++
 rtl/gs_i2s_tx_if.sv | 9 +
 rtl/gs_bclk_gen.sv | 32 +++
 rtl/gs_i2s_tx.sv | 82 ++++++++
 tb/tb_gs_i2s_tx.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/gs_audio_pkg.sv
// Shared constants and GS-sum to PCM16 conversion for the General Sound audio path.
package gs_audio_pkg;

   localparam int FRAME_BITS = 32;
   localparam int SLOT_BITS  = 16;
   localparam int GS_MID     = 256;

   // Offset-binary 9-bit sum to signed 16-bit; shifting right keeps the sign.
   function automatic logic [15:0] gs_to_pcm16(input logic [8:0] in9,
                                               input logic [2:0] vol,
                                               input logic       mute);
      logic signed [8:0]  s9;
      logic signed [15:0] s16;
      s9  = signed'(in9 - 9'(GS_MID));
      s16 = {s9, 7'b0};
      s16 = s16 >>> vol;
      return mute ? 16'h0000 : s16;
   endfunction

endpackage

// File: rtl/gs_i2s_tx_if.sv
// I2S serial link between the GS transmitter and the board codec.
interface gs_i2s_tx_if;
   logic i2s_bclk;
   logic i2s_lrck;
   logic i2s_data;

   modport master (output i2s_bclk, output i2s_lrck, output i2s_data);
   modport slave  (input  i2s_bclk, input  i2s_lrck, input  i2s_data);
endinterface

// File: rtl/gs_bclk_gen.sv
// Bit-clock divider: BCLK toggles every CLK_DIV clk_sys cycles; bclk_fall marks the 1->0 cycle.
module gs_bclk_gen #(
   parameter int unsigned CLK_DIV = 14
) (
   input  logic clk_sys,
   input  logic reset_n,
   output logic bclk,
   output logic bclk_fall
);

   localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);

   logic [7:0] div_cnt;
   logic       div_tc;

   assign div_tc    = (div_cnt == 8'd0);
   assign bclk_fall = div_tc & bclk;

   // Down-counter reloads on terminal count, so the first toggle lands CLK_DIV cycles after reset.
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         div_cnt <= DIV_LOAD;
         bclk    <= 1'b0;
      end else if (div_tc) begin
         div_cnt <= DIV_LOAD;
         bclk    <= ~bclk;
      end else begin
         div_cnt <= div_cnt - 8'd1;
      end
   end

endmodule

// File: rtl/gs_i2s_tx.sv
// GS left/right sums to I2S: coherent per-frame capture, PCM16 conversion and MSB-first serialisation.
module gs_i2s_tx
   import gs_audio_pkg::*;
#(
   parameter int unsigned CLK_DIV = 14
) (
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic [8:0] in_l,
   input  logic [8:0] in_r,
   input  logic       mute,
   input  logic [2:0] vol,
   output logic       sample_strobe,
   gs_i2s_tx_if.master i2s
);

   localparam int F_W = $clog2(FRAME_BITS);
   localparam logic [F_W-1:0] F_CAPTURE = '0;
   localparam logic [F_W-1:0] F_LOAD_L  = F_W'(1);
   localparam logic [F_W-1:0] F_LOAD_R  = F_W'(SLOT_BITS + 1);

   logic           bclk;
   logic           bclk_fall;
   logic [F_W-1:0] f;
   logic [F_W-1:0] f_nxt;
   logic [15:0]    hold_l;
   logic [15:0]    hold_r;
   logic [15:0]    sh;
   logic [15:0]    sh_nxt;
   logic           lrck_q;
   logic           data_q;
   logic           strobe_q;

   gs_bclk_gen #(.CLK_DIV(CLK_DIV)) u_bclk_gen (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .bclk      (bclk),
      .bclk_fall (bclk_fall)
   );

   // Capture happens at f->0 and loads at f->1/17, so hold_* is always settled when loaded.
   always_comb begin
      f_nxt  = f + F_W'(1);
      sh_nxt = {sh[14:0], 1'b0};
      if (f_nxt == F_LOAD_L) begin
         sh_nxt = hold_l;
      end else if (f_nxt == F_LOAD_R) begin
         sh_nxt = hold_r;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         f        <= '0;
         hold_l   <= '0;
         hold_r   <= '0;
         sh       <= '0;
         lrck_q   <= 1'b0;
         data_q   <= 1'b0;
         strobe_q <= 1'b0;
      end else begin
         strobe_q <= 1'b0;
         if (bclk_fall) begin
            f      <= f_nxt;
            lrck_q <= f_nxt[F_W-1];
            sh     <= sh_nxt;
            data_q <= sh_nxt[15];
            if (f_nxt == F_CAPTURE) begin
               hold_l   <= gs_to_pcm16(in_l, vol, mute);
               hold_r   <= gs_to_pcm16(in_r, vol, mute);
               strobe_q <= 1'b1;
            end
         end
      end
   end

   assign i2s.i2s_bclk  = bclk;
   assign i2s.i2s_lrck  = lrck_q;
   assign i2s.i2s_data  = data_q;
   assign sample_strobe = strobe_q;

endmodule

// File: tb/tb_gs_i2s_tx.sv
// Directed bench for gs_i2s_tx: decodes I2S words at BCLK rise for CLK_DIV=14 and CLK_DIV=1 instances.
module tb_gs_i2s_tx;

   logic       clk = 1'b0;
   logic       rst14, rst1;
   logic [8:0] in_l, in_r;
   logic       mute;
   logic [2:0] vol;
   logic       strobe14, strobe1;
   int         total = 0;
   int         bad = 0;

   logic       sel1;
   logic       bclk_s, lrck_s, data_s, strb_s;
   int         div_s;

   gs_i2s_tx_if if14 ();
   gs_i2s_tx_if if1 ();

   gs_i2s_tx #(.CLK_DIV(14)) u14 (
      .clk_sys(clk), .reset_n(rst14), .in_l(in_l), .in_r(in_r), .mute(mute), .vol(vol),
      .sample_strobe(strobe14), .i2s(if14)
   );

   gs_i2s_tx #(.CLK_DIV(1)) u1 (
      .clk_sys(clk), .reset_n(rst1), .in_l(in_l), .in_r(in_r), .mute(mute), .vol(vol),
      .sample_strobe(strobe1), .i2s(if1)
   );

   always #5 clk = ~clk;

   always_comb begin
      bclk_s = sel1 ? if1.i2s_bclk : if14.i2s_bclk;
      lrck_s = sel1 ? if1.i2s_lrck : if14.i2s_lrck;
      data_s = sel1 ? if1.i2s_data : if14.i2s_data;
      strb_s = sel1 ? strobe1 : strobe14;
      div_s  = sel1 ? 1 : 14;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_strobe(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 64 * div_s + 256; i++) begin
         tick();
         if (strb_s) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Decodes the words captured at the next strobe; optionally changes in_l at a given f.
   task automatic decode(input string tag, input int chg_fall, input logic [8:0] chg_val,
                         output logic [15:0] wl, output logic [15:0] wr, output bit lr_ok);
      bit   ok;
      int   rises, falls;
      logic prev;
      wl = '0; wr = '0; lr_ok = 1'b1;
      wait_strobe(ok);
      check({tag, "_strobe_seen"}, 32'(ok), 32'd1);
      if (!ok) return;
      rises = 0; falls = 0;
      prev = bclk_s;
      for (int i = 0; i < 70 * div_s + 16; i++) begin
         tick();
         if (i == 0) check({tag, "_strobe_width"}, 32'(strb_s), 32'd0);
         if (bclk_s && !prev) begin
            if (rises >= 1 && rises <= 16) wl = {wl[14:0], data_s};
            if (rises >= 17 && rises <= 32) wr = {wr[14:0], data_s};
            if (rises >= 1 && rises <= 15 && lrck_s) lr_ok = 1'b0;
            if (rises >= 17 && rises <= 31 && !lrck_s) lr_ok = 1'b0;
            rises++;
         end
         if (!bclk_s && prev) begin
            falls++;
            if (falls == chg_fall) in_l = chg_val;
         end
         prev = bclk_s;
         if (rises == 33) break;
      end
      check({tag, "_bits_collected"}, 32'(rises), 32'd33);
   endtask

   task automatic mid_reset(input bit which);
      bit   ok;
      int   falls, n_rise, n_str;
      logic prev;
      string tg;
      sel1 = which;
      tg = $sformatf("midrst_div%0d", which ? 1 : 14);
      wait_strobe(ok);
      check({tg, "_strobe_seen"}, 32'(ok), 32'd1);
      falls = 0;
      prev = bclk_s;
      for (int i = 0; i < 40 * div_s && falls < 9; i++) begin
         tick();
         if (!bclk_s && prev) falls++;
         prev = bclk_s;
      end
      for (int i = 0; i < 4 * div_s && !bclk_s; i++) tick();
      check({tg, "_pre_f9_bclk_data"}, {30'd0, bclk_s, data_s}, 32'b11);
      if (which) rst1 = 1'b0; else rst14 = 1'b0;
      tick();
      check({tg, "_outputs_zero"}, {28'd0, bclk_s, lrck_s, data_s, strb_s}, 32'd0);
      if (which) rst1 = 1'b1; else rst14 = 1'b1;
      n_rise = 0; n_str = 0;
      for (int n = 1; n <= 64 * div_s + 64; n++) begin
         tick();
         if (bclk_s && n_rise == 0) n_rise = n;
         if (strb_s) begin
            n_str = n;
            break;
         end
      end
      check({tg, "_first_rise"}, 32'(n_rise), 32'(div_s));
      check({tg, "_first_strobe"}, 32'(n_str), 32'(64 * div_s));
   endtask

   initial begin
      logic [15:0] wl, wr;
      bit          lr_ok;
      int          r14, s14, r1, s1;

      sel1 = 1'b0;
      rst14 = 1'b0; rst1 = 1'b0;
      in_l = 9'd256; in_r = 9'd256; mute = 1'b0; vol = 3'd0;
      repeat (10) tick();
      check("rst_outputs_div14", {28'd0, if14.i2s_bclk, if14.i2s_lrck, if14.i2s_data, strobe14}, 32'd0);
      check("rst_outputs_div1", {28'd0, if1.i2s_bclk, if1.i2s_lrck, if1.i2s_data, strobe1}, 32'd0);

      rst14 = 1'b1; rst1 = 1'b1;
      r14 = 0; s14 = 0; r1 = 0; s1 = 0;
      for (int n = 1; n <= 64 * 14 + 32; n++) begin
         tick();
         if (if14.i2s_bclk && r14 == 0) r14 = n;
         if (strobe14 && s14 == 0) s14 = n;
         if (if1.i2s_bclk && r1 == 0) r1 = n;
         if (strobe1 && s1 == 0) s1 = n;
         if (s14 != 0) break;
      end
      check("pwrup_rise_div14", 32'(r14), 32'd14);
      check("pwrup_strobe_div14", 32'(s14), 32'd896);
      check("pwrup_rise_div1", 32'(r1), 32'd1);
      check("pwrup_strobe_div1", 32'(s1), 32'd64);

      in_l = 9'd510; in_r = 9'd0;
      decode("full", -1, 9'd0, wl, wr, lr_ok);
      check("full_left", 32'(wl), 32'h7F00);
      check("full_right", 32'(wr), 32'h8000);
      check("full_lrck", 32'(lr_ok), 32'd1);

      in_l = 9'd256; in_r = 9'd256;
      decode("mid", -1, 9'd0, wl, wr, lr_ok);
      check("mid_left", 32'(wl), 32'h0000);
      check("mid_right", 32'(wr), 32'h0000);

      in_l = 9'd257; in_r = 9'd255;
      decode("mid1", -1, 9'd0, wl, wr, lr_ok);
      check("mid1_left", 32'(wl), 32'h0080);
      check("mid1_right", 32'(wr), 32'hFF80);

      vol = 3'd1; in_l = 9'd510; in_r = 9'd0;
      decode("vol1", -1, 9'd0, wl, wr, lr_ok);
      check("vol1_left", 32'(wl), 32'h3F80);
      check("vol1_right", 32'(wr), 32'hC000);

      vol = 3'd7; in_l = 9'd0; in_r = 9'd510;
      decode("vol7", -1, 9'd0, wl, wr, lr_ok);
      check("vol7_left", 32'(wl), 32'hFF00);
      check("vol7_right", 32'(wr), 32'h00FE);

      vol = 3'd0; mute = 1'b1; in_l = 9'd510; in_r = 9'd0;
      decode("mute", -1, 9'd0, wl, wr, lr_ok);
      check("mute_left", 32'(wl), 32'h0000);
      check("mute_right", 32'(wr), 32'h0000);
      mute = 1'b0;

      in_l = 9'd300; in_r = 9'd256;
      decode("coh_a", 20, 9'd100, wl, wr, lr_ok);
      check("coh_current_left", 32'(wl), 32'h1600);
      check("coh_current_right", 32'(wr), 32'h0000);
      decode("coh_b", -1, 9'd0, wl, wr, lr_ok);
      check("coh_next_left", 32'(wl), 32'hB200);

      sel1 = 1'b1;
      in_l = 9'd510; in_r = 9'd0;
      decode("div1", -1, 9'd0, wl, wr, lr_ok);
      check("div1_left", 32'(wl), 32'h7F00);
      check("div1_right", 32'(wr), 32'h8000);
      check("div1_lrck", 32'(lr_ok), 32'd1);

      in_l = 9'd257; in_r = 9'd256;
      mid_reset(1'b1);
      mid_reset(1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
